// File: rtl/cnn_pkg.sv
// Shared constants for the pool/unpool stages: operating modes, argmax index
// encoding and the unpool row-pair state encoding.
package cnn_pkg;

  localparam int unsigned MODE_UNPOOL  = 0;
  localparam int unsigned MODE_NEAREST = 1;

  localparam logic [1:0] IDX_00 = 2'd0;
  localparam logic [1:0] IDX_01 = 2'd1;
  localparam logic [1:0] IDX_10 = 2'd2;
  localparam logic [1:0] IDX_11 = 2'd3;

  typedef enum logic [1:0] {
    S_TOP = 2'd0,
    S_BOT = 2'd1
  } state_t;

  // Argmax code for a position inside the 2x2 window.
  function automatic logic [1:0] pos_idx(input logic dr, input logic dc);
    logic [1:0] code;
    unique case ({dr, dc})
      2'b00:   code = IDX_00;
      2'b01:   code = IDX_01;
      2'b10:   code = IDX_10;
      default: code = IDX_11;
    endcase
    return code;
  endfunction

  // True when the stored value belongs at window position (dr,dc).
  function automatic logic idx_hit(input logic [1:0] idx, input logic dr,
                                   input logic dc, input int unsigned mode);
    return (mode == MODE_NEAREST) || (idx == pos_idx(dr, dc));
  endfunction

endpackage

// File: rtl/unpool_line_buf.sv
// Register-array row buffer: one synchronous write port, one combinational read.
module unpool_line_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are never cleared; every entry is written in the top row before
  // the bottom row reads it back.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxunpool2_stream.sv
// Streaming 2x2 max-unpooling: each pooled element expands to a 2x2 window,
// emitted row-major at double resolution, one pixel per beat.
module maxunpool2_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_W       = 16,
  parameter int unsigned IN_H       = 16,
  parameter int unsigned MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int unsigned COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

  state_t            state, state_d;
  logic [COL_W-1:0]  col, col_d;
  logic [ROW_W-1:0]  row, row_d;
  logic              beat, beat_d;
  logic [ENT_W-1:0]  cur, cur_d;
  logic [ENT_W-1:0]  lb_wdata, lb_rdata;
  logic                  out_valid_d, sof_d, eol_d, eof_d;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic slot_free_c, in_fire_c, last_col_c;

  // Entry layout is {idx, value}.
  function automatic logic [DATA_WIDTH-1:0] pick(input logic [ENT_W-1:0] e,
                                                 input logic dr, input logic dc);
    return idx_hit(e[ENT_W-1 -: 2], dr, dc, MODE) ? e[DATA_WIDTH-1:0] : '0;
  endfunction

  assign slot_free_c = !out_valid || out_ready;
  assign in_ready    = (state == S_TOP) && !beat && slot_free_c;
  assign in_fire_c   = in_valid && in_ready;
  assign last_col_c  = (col == COL_LAST);
  assign lb_wdata    = {in_idx, in_data};

  unpool_line_buf #(
    .DEPTH (IN_W),
    .WIDTH (ENT_W),
    .AW    (COL_W)
  ) u_lbuf (
    .clk   (clk),
    .we    (in_fire_c),
    .waddr (col),
    .wdata (lb_wdata),
    .raddr (col),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_TOP;
      col       <= '0;
      row       <= '0;
      beat      <= 1'b0;
      cur       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      state     <= state_d;
      col       <= col_d;
      row       <= row_d;
      beat      <= beat_d;
      cur       <= cur_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sof   <= sof_d;
      out_eol   <= eol_d;
      out_eof   <= eof_d;
    end
  end

  // Next-state and output-register load; everything holds while stalled.
  always_comb begin
    state_d     = state;
    col_d       = col;
    row_d       = row;
    beat_d      = beat;
    cur_d       = cur;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    sof_d       = out_sof;
    eol_d       = out_eol;
    eof_d       = out_eof;

    if (slot_free_c) begin
      case (state)
        S_TOP: begin
          if (!beat) begin
            if (in_fire_c) begin
              cur_d       = lb_wdata;
              out_valid_d = 1'b1;
              out_data_d  = pick(lb_wdata, 1'b0, 1'b0);
              sof_d       = (row == '0) && (col == '0);
              eol_d       = 1'b0;
              eof_d       = 1'b0;
              beat_d      = 1'b1;
            end else begin
              out_valid_d = 1'b0;
            end
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = pick(cur, 1'b0, 1'b1);
            sof_d       = 1'b0;
            eol_d       = last_col_c;
            eof_d       = 1'b0;
            beat_d      = 1'b0;
            if (last_col_c) begin
              col_d   = '0;
              state_d = S_BOT;
            end else begin
              col_d = col + COL_W'(1);
            end
          end
        end
        S_BOT: begin
          out_valid_d = 1'b1;
          out_data_d  = pick(lb_rdata, 1'b1, beat);
          sof_d       = 1'b0;
          eol_d       = last_col_c && beat;
          eof_d       = last_col_c && beat && (row == ROW_LAST);
          beat_d      = !beat;
          if (beat) begin
            if (last_col_c) begin
              col_d   = '0;
              state_d = S_TOP;
              row_d   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
              col_d = col + COL_W'(1);
            end
          end
        end
        default: begin
          state_d     = S_TOP;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxunpool2_stream.sv
// Bench for maxunpool2_stream: a 2x2-frame UNPOOL instance and a 1x1-frame
// NEAREST instance, checked against a window-expansion reference model.
module tb_maxunpool2_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } px_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [1:0] in_idx;
  logic       out_sof, out_eol, out_eof;
  logic       n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [7:0] n_in_data, n_out_data;
  logic [1:0] n_in_idx;
  logic       n_out_sof, n_out_eol, n_out_eof;

  int total = 0;
  int bad   = 0;

  px_t        obs[$];
  px_t        nobs[$];
  px_t        exp_q[$];
  logic [7:0] ev[$];
  logic [1:0] ei[$];

  always #5 clk = ~clk;

  maxunpool2_stream #(.DATA_WIDTH(8), .IN_W(2), .IN_H(2), .MODE(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  maxunpool2_stream #(.DATA_WIDTH(8), .IN_W(1), .IN_H(1), .MODE(1)) n_dut (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_idx(n_in_idx),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .out_sof(n_out_sof), .out_eol(n_out_eol), .out_eof(n_out_eof)
  );

  // Record every pixel that will transfer on the coming edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      obs.push_back({out_data, out_sof, out_eol, out_eof});
    if (!rst && n_out_valid && n_out_ready)
      nobs.push_back({n_out_data, n_out_sof, n_out_eol, n_out_eof});
  end

  // Expand whole frames of (value,idx) elements into the expected pixel stream.
  task automatic build_exp(input int w, input int h, input int mode);
    int nf;
    exp_q.delete();
    nf = ev.size() / (w * h);
    for (int f = 0; f < nf; f++)
      for (int r = 0; r < h; r++)
        for (int dr = 0; dr < 2; dr++)
          for (int c = 0; c < w; c++)
            for (int dc = 0; dc < 2; dc++) begin
              int   e;
              px_t  p;
              e     = f * w * h + r * w + c;
              p.d   = (mode == 1 || ei[e] == 2'(dr * 2 + dc)) ? ev[e] : 8'h00;
              p.sof = (r == 0 && dr == 0 && c == 0 && dc == 0);
              p.eol = (c == w - 1 && dc == 1);
              p.eof = p.eol && dr == 1 && r == h - 1;
              exp_q.push_back(p);
            end
  endtask

  // Present one element from posedge+1; returns the refused cycles, -1 on timeout.
  task automatic send(input logic [7:0] v, input logic [1:0] i, output int waits);
    logic fired;
    fired   = 1'b0;
    waits   = 0;
    in_data = v;
    in_idx  = i;
    in_valid = 1'b1;
    while (!fired && waits < 300) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      if (!fired) waits++;
    end
    in_valid = 1'b0;
    if (!fired) waits = -1;
  endtask

  task automatic wait_obs(input int n);
    for (int t = 0; t < 3000 && obs.size() < n; t++) @(posedge clk);
    #1;
  endtask

  task automatic load_scenario();
    ev = '{8'd9, 8'd7, 8'd4, 8'd6};
    ei = '{2'd0, 2'd3, 2'd1, 2'd2};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_data = '0; n_in_idx = '0; n_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++; if ({out_sof, out_eol, out_eof} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {out_sof, out_eol, out_eof}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL reset_n_in_ready: got %b want 1", n_in_ready); end
    @(posedge clk); #1;
    obs.delete(); nobs.delete();
  endtask

  task automatic test_unpool_frame();
    logic [7:0] lit [16];
    int w;
    lit = '{8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7,
            8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd0};
    load_scenario();
    build_exp(2, 2, 0);
    obs.delete();
    for (int k = 0; k < 4; k++) send(ev[k], ei[k], w);
    wait_obs(16);
    repeat (4) @(posedge clk);
    #1;
    total++; if (obs.size() != 16) begin bad++; $display("FAIL frame_count: got %0d want 16", obs.size()); end
    for (int k = 0; k < 16; k++) begin
      px_t got;
      got = (k < obs.size()) ? obs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL frame_px%0d: got %h want %h", k, got, exp_q[k]); end
      total++; if (got.d !== lit[k]) begin bad++; $display("FAIL frame_lit%0d: got %h want %h", k, got.d, lit[k]); end
    end
  endtask

  task automatic test_nearest();
    ev = '{8'hAB}; ei = '{2'd2};
    for (int k = 0; k < 3; k++) begin
      ev.push_back(8'($urandom_range(0, 255)));
      ei.push_back(2'($urandom_range(0, 3)));
    end
    build_exp(1, 1, 1);
    nobs.delete();
    for (int k = 0; k < 4; k++) begin
      logic fired;
      fired = 1'b0;
      n_in_data = ev[k]; n_in_idx = ei[k]; n_in_valid = 1'b1;
      for (int t = 0; t < 300 && !fired; t++) begin
        @(negedge clk); fired = n_in_ready;
        @(posedge clk); #1;
      end
      n_in_valid = 1'b0;
    end
    for (int t = 0; t < 300 && nobs.size() < 16; t++) @(posedge clk);
    #1;
    total++; if (nobs.size() != 16) begin bad++; $display("FAIL nearest_count: got %0d want 16", nobs.size()); end
    for (int k = 0; k < 16; k++) begin
      px_t got;
      got = (k < nobs.size()) ? nobs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL nearest_px%0d: got %h want %h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    load_scenario();
    build_exp(2, 2, 0);
    obs.delete();
    fork
      begin
        int w;
        for (int k = 0; k < 4; k++) send(ev[k], ei[k], w);
      end
      begin
        px_t snap;
        for (int t = 0; t < 3000 && obs.size() < 5; t++) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          px_t now;
          @(negedge clk);
          now = {out_data, out_sof, out_eol, out_eof};
          if (k == 0) begin
            snap = now;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
            total++; if (now !== exp_q[5]) begin bad++; $display("FAIL bp_held_px: got %h want %h", now, exp_q[5]); end
          end else begin
            total++; if (now !== snap) begin bad++; $display("FAIL bp_stable%0d: got %h want %h", k, now, snap); end
          end
          total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_obs(16);
    repeat (4) @(posedge clk);
    #1;
    total++; if (obs.size() != 16) begin bad++; $display("FAIL bp_count: got %0d want 16", obs.size()); end
    for (int k = 0; k < 16; k++) begin
      px_t got;
      got = (k < obs.size()) ? obs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL bp_px%0d: got %h want %h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_input_during_bot();
    int w;
    ev = '{8'd9, 8'd7, 8'h11, 8'd6};
    ei = '{2'd0, 2'd3, 2'd0, 2'd2};
    build_exp(2, 2, 0);
    obs.delete();
    send(ev[0], ei[0], w);
    send(ev[1], ei[1], w);
    send(ev[2], ei[2], w);
    total++; if (w != 5) begin bad++; $display("FAIL bot_refused_cycles: got %0d want 5", w); end
    total++; if (obs.size() != 8) begin bad++; $display("FAIL bot_accept_point: got %0d want 8", obs.size()); end
    send(ev[3], ei[3], w);
    wait_obs(16);
    total++; if (obs.size() != 16) begin bad++; $display("FAIL bot_count: got %0d want 16", obs.size()); end
    for (int k = 0; k < 16; k++) begin
      px_t got;
      got = (k < obs.size()) ? obs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL bot_px%0d: got %h want %h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_random_frames();
    ev.delete(); ei.delete();
    for (int k = 0; k < 12; k++) begin
      ev.push_back(8'($urandom_range(0, 255)));
      ei.push_back(2'($urandom_range(0, 3)));
    end
    build_exp(2, 2, 0);
    obs.delete();
    fork
      begin
        int w;
        for (int k = 0; k < 12; k++) begin
          send(ev[k], ei[k], w);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int t = 0; t < 3000 && obs.size() < 48; t++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_obs(48);
    total++; if (obs.size() != 48) begin bad++; $display("FAIL rand_count: got %0d want 48", obs.size()); end
    for (int k = 0; k < 48; k++) begin
      px_t got;
      got = (k < obs.size()) ? obs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL rand_px%0d: got %h want %h", k, got, exp_q[k]); end
    end
  endtask

  task automatic test_reset_midframe();
    int w;
    load_scenario();
    build_exp(2, 2, 0);
    obs.delete();
    send(ev[0], ei[0], w);
    send(ev[1], ei[1], w);
    wait_obs(6);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    obs.delete();
    for (int k = 0; k < 4; k++) send(ev[k], ei[k], w);
    wait_obs(16);
    total++; if (obs.size() != 16) begin bad++; $display("FAIL midrst_count: got %0d want 16", obs.size()); end
    for (int k = 0; k < 16; k++) begin
      px_t got;
      got = (k < obs.size()) ? obs[k] : 'x;
      total++; if (got !== exp_q[k]) begin bad++; $display("FAIL midrst_px%0d: got %h want %h", k, got, exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_unpool_frame();
    test_nearest();
    test_backpressure();
    test_input_during_bot();
    test_random_frames();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
